// File: rtl/bram_rd_sequencer_pkg.sv
// rtl/bram_rd_sequencer_pkg.sv - shared defaults, state encoding and byte math
package bram_rd_sequencer_pkg;

  localparam int DEFAULT_WIDTH_DATA = 48;
  localparam int DEFAULT_WIDTH_ADDR = 8;
  localparam int BYTES_PER_WORD     = DEFAULT_WIDTH_DATA / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic int bytes_per_word(input int width_data);
    return width_data / 8;
  endfunction

endpackage

// File: rtl/bram_rd_sequencer_if.sv
// rtl/bram_rd_sequencer_if.sv - control, BRAM read port and UART byte stream bundle
interface bram_rd_sequencer_if #(
  parameter int WIDTH_DATA = bram_rd_sequencer_pkg::DEFAULT_WIDTH_DATA,
  parameter int WIDTH_ADDR = bram_rd_sequencer_pkg::DEFAULT_WIDTH_ADDR
);
  import bram_rd_sequencer_pkg::*;

  logic                  i_start;
  logic [WIDTH_ADDR-1:0] i_base_addr;
  logic [WIDTH_ADDR:0]   i_word_cnt;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_rd_en;
  logic [WIDTH_ADDR-1:0] o_raddr;
  logic [WIDTH_DATA-1:0] i_rdata;
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
  logic                  i_tx_ready;

  modport slave (
    input  i_start, i_base_addr, i_word_cnt, i_rdata, i_tx_ready,
    output o_busy, o_done, o_rd_en, o_raddr, o_tx_data, o_tx_valid
  );

  modport master (
    output i_start, i_base_addr, i_word_cnt, i_rdata, i_tx_ready,
    input  o_busy, o_done, o_rd_en, o_raddr, o_tx_data, o_tx_valid
  );

endinterface

// File: rtl/bram_rd_sequencer_word_serializer.sv
// rtl/bram_rd_sequencer_word_serializer.sv - holds one BRAM word and emits it LSB byte first
module word_serializer
  import bram_rd_sequencer_pkg::*;
#(
  parameter int WIDTH_DATA = DEFAULT_WIDTH_DATA
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [WIDTH_DATA-1:0] i_word,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  output logic                  o_last_hs
);

  localparam int BPW   = bytes_per_word(WIDTH_DATA);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  logic [BPW-1:0][7:0] word_q;
  logic [IDX_W-1:0]    idx_q;
  logic                valid_q;
  logic                hs;

  assign hs         = valid_q && i_tx_ready;
  assign o_last_hs  = hs && (idx_q == LAST_IDX);
  // Byte mux is driven only from registers, so the byte stays put during stalls.
  assign o_tx_data  = word_q[idx_q];
  assign o_tx_valid = valid_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_load) begin
      word_q  <= i_word;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (hs) begin
      if (idx_q == LAST_IDX) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_rd_sequencer.sv
// rtl/bram_rd_sequencer.sv - reads a block of BRAM words and streams them out as bytes
module bram_rd_sequencer
  import bram_rd_sequencer_pkg::*;
#(
  parameter int WIDTH_DATA = DEFAULT_WIDTH_DATA,
  parameter int WIDTH_ADDR = DEFAULT_WIDTH_ADDR
) (
  input  logic                i_clk,
  input  logic                i_rst,
  bram_rd_sequencer_if.slave  bus
);

  localparam logic [WIDTH_ADDR:0] CNT_ONE = (WIDTH_ADDR + 1)'(1);

  state_t                state_q, state_d;
  logic [WIDTH_ADDR-1:0] addr_q;
  logic [WIDTH_ADDR:0]   cnt_q;
  logic                  accept;
  logic                  ser_load;
  logic                  last_hs;
  logic                  rd_en;
  logic                  done;
  logic [7:0]            tx_data;
  logic                  tx_valid;

  assign accept = (state_q == IDLE) && bus.i_start && (bus.i_word_cnt != '0);

  word_serializer #(.WIDTH_DATA(WIDTH_DATA)) u_ser (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (ser_load),
    .i_word     (bus.i_rdata),
    .i_tx_ready (bus.i_tx_ready),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .o_last_hs  (last_hs)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_en    = 1'b0;
    ser_load = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = (bus.i_word_cnt == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        rd_en   = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        // cnt_q still holds the pre-decrement count during the final handshake.
        if (last_hs) begin
          state_d = (cnt_q == CNT_ONE) ? DONE : RD_REQ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address wraps naturally through its WIDTH_ADDR-bit register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      addr_q <= bus.i_base_addr;
      cnt_q  <= bus.i_word_cnt;
    end else if (last_hs) begin
      addr_q <= addr_q + 1'b1;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_done     = done;
  assign bus.o_rd_en    = rd_en;
  assign bus.o_raddr    = addr_q;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_valid = tx_valid;

endmodule

// File: tb/tb_bram_rd_sequencer.sv
// tb/tb_bram_rd_sequencer.sv - scoreboard bench for bram_rd_sequencer
module tb_bram_rd_sequencer;

  localparam int WD    = 48;
  localparam int WA    = 8;
  localparam int NB    = WD / 8;
  localparam int DEPTH = 1 << WA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_rd_sequencer_if #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA)) bus ();

  bram_rd_sequencer #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Registered-output BRAM: data appears the cycle after the read enable.
  logic [WD-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.o_rd_en) bus.i_rdata <= mem[bus.o_raddr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]    exp_byte [$];
  logic [WA-1:0] exp_addr [$];
  int  hs_cnt       = 0;
  int  done_cnt     = 0;
  int  done_cyc     = -1;
  int  first_rd_cyc = -1;
  int  first_tx_cyc = -1;
  int  d0           = 0;
  int  hs0          = 0;
  bit  rdy_rand     = 1'b0;
  bit  stalled      = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    bus.i_tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: consumes the scoreboard whenever the DUT reads or hands over a byte.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_rd_en) begin
        check("rd_en_expected", bus.o_rd_en, longint'(exp_addr.size() != 0));
        if (exp_addr.size() != 0) check("raddr", bus.o_raddr, exp_addr.pop_front());
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (stalled) begin
        check("valid_hold", bus.o_tx_valid, 1);
        check("data_hold", bus.o_tx_data, prev_data);
      end
      if (bus.o_tx_valid) begin
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        if (bus.i_tx_ready) begin
          hs_cnt++;
          check("byte_expected", 1, longint'(exp_byte.size() != 0));
          if (exp_byte.size() != 0) check("tx_data", bus.o_tx_data, exp_byte.pop_front());
        end
      end
      stalled   = bus.o_tx_valid && !bus.i_tx_ready && !rst;
      prev_data = bus.o_tx_data;
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic issue(input logic [WA-1:0] base, input logic [WA:0] cnt,
                       input bit chk_idle, output int s);
    int a;
    bus.i_start     = 1'b1;
    bus.i_base_addr = base;
    bus.i_word_cnt  = cnt;
    s            = cyc;
    first_rd_cyc = -1;
    first_tx_cyc = -1;
    d0           = done_cnt;
    hs0          = hs_cnt;
    for (int w = 0; w < int'(cnt); w++) begin
      a = (int'(base) + w) % DEPTH;
      exp_addr.push_back(WA'(a));
      for (int b = 0; b < NB; b++) exp_byte.push_back(8'((mem[a] >> (8 * b)) & 48'hFF));
    end
    if (chk_idle) begin
      @(negedge clk);
      check("rst_busy", bus.o_busy, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_rd_en", bus.o_rd_en, 0);
      check("rst_raddr", bus.o_raddr, 0);
      check("rst_tx_valid", bus.o_tx_valid, 0);
      check("rst_tx_data", bus.o_tx_data, 0);
    end
    @(posedge clk);
    #1;
    bus.i_start     = 1'b0;
    bus.i_base_addr = WA'($urandom);
    bus.i_word_cnt  = (WA + 1)'($urandom);
  endtask

  task automatic finish_blk(input int s, input int cnt, input bit timed);
    int lim;
    int n;
    lim = 200 + cnt * 60;
    n   = 0;
    while (done_cnt == d0 && n < lim) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", done_cnt, d0 + 1);
    check("byte_count", hs_cnt - hs0, cnt * NB);
    check("byteq_empty", exp_byte.size(), 0);
    check("addrq_empty", exp_addr.size(), 0);
    if (timed) begin
      check("done_cycle", done_cyc, s + 1 + cnt * (2 + NB));
      if (cnt > 0) begin
        check("rd_latency", first_rd_cyc, s + 1);
        check("tx_latency", first_tx_cyc, s + 3);
      end else begin
        check("no_rd", first_rd_cyc, -1);
        check("no_tx", first_tx_cyc, -1);
      end
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("busy_after_done", bus.o_busy, 0);
    check("single_done", done_cnt, d0 + 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    int n;
    int dr;
    int c;
    logic [WA-1:0] base;
    for (int i = 0; i < DEPTH; i++) mem[i] = WD'({$urandom, $urandom});
    bus.i_start     = 1'b0;
    bus.i_base_addr = '0;
    bus.i_word_cnt  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.o_busy, 0);
    check("reset_done", bus.o_done, 0);
    check("reset_rd_en", bus.o_rd_en, 0);
    check("reset_raddr", bus.o_raddr, 0);
    check("reset_tx_valid", bus.o_tx_valid, 0);
    check("reset_tx_data", bus.o_tx_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    mem[8'h10] = 48'h0605_0403_0201;
    issue(8'h10, 1, 1'b0, s);
    finish_blk(s, 1, 1'b1);

    issue(8'hFE, 3, 1'b0, s);
    finish_blk(s, 3, 1'b1);

    issue(8'h33, 0, 1'b0, s);
    finish_blk(s, 0, 1'b1);

    rdy_rand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      c = $urandom_range(1, 4);
      issue(WA'($urandom), (WA + 1)'(c), 1'b0, s);
      finish_blk(s, c, 1'b0);
    end
    rdy_rand = 1'b0;

    issue(8'h80, 2, 1'b0, s);
    n = 0;
    while (!bus.o_tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("v5_valid_seen", bus.o_tx_valid, 1);
    @(posedge clk);
    #1;
    bus.i_start     = 1'b1;
    bus.i_base_addr = 8'h05;
    bus.i_word_cnt  = 5;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    finish_blk(s, 2, 1'b1);

    issue(8'hC0, 3, 1'b0, s);
    n = 0;
    while ((hs_cnt - hs0) < NB + 3 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("v6_bytes_before_rst", hs_cnt - hs0, NB + 3);
    dr = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_byte.delete();
    exp_addr.delete();
    base = WA'($urandom);
    issue(base, 1, 1'b1, s);
    check("v6_no_done_abort", done_cnt, dr);
    finish_blk(s, 1, 1'b1);

    issue(WA'($urandom), (WA + 1)'(DEPTH), 1'b0, s);
    finish_blk(s, DEPTH, 1'b1);

    for (int k = 0; k < 8; k++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      c = $urandom_range(0, 6);
      issue(WA'($urandom), (WA + 1)'(c), 1'b0, s);
      finish_blk(s, c, 1'b0);
    end
    rdy_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
